// File: rtl/as_seq_pkg.sv
// Shared definitions for the iterative shift unit: operation codes, FSM states
// and default datapath sizing.
package as_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/as_step.sv
// Single-bit-position shifter: produces one step of SLL/SRL/SRA/ROR.
module as_step
    import as_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  op_e              op,
    output logic [WIDTH-1:0] r_next
);

    always_comb begin
        r_next = r;
        case (op)
            OP_SLL: r_next = {r[WIDTH-2:0], 1'b0};
            OP_SRL: r_next = {1'b0, r[WIDTH-1:1]};
            OP_SRA: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROR: r_next = {r[0], r[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/as_seq.sv
// Iterative shift unit: captures an operand on start, then applies one
// single-bit step per clock until the requested amount has been shifted.
module as_seq
    import as_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state_reg, state_next;
    logic [SHW-1:0]   count_reg, count_next;
    op_e              op_reg, op_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] step_out;

    as_step #(.WIDTH(WIDTH)) u_step (
        .r      (result_reg),
        .op     (op_reg),
        .r_next (step_out)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            op_reg     <= OP_SLL;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // busy/done are computed from the state being entered so both are registered
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        result_next = result_reg;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    result_next = din;
                    count_next  = shamt;
                    op_next     = op_e'(op);
                    if (shamt != '0) begin
                        state_next = S_SHIFT;
                        busy_next  = 1'b1;
                    end else begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                result_next = step_out;
                count_next  = count_reg - SHW'(1);
                if (count_reg == SHW'(1)) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_as_seq.sv
// Scoreboard bench for as_seq: stimulus pushes expected results, a monitor
// pops them on every done pulse and checks value, timing and busy.
module tb_as_seq;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic [4:0]    shamt = '0;
    logic [1:0]    op = 2'b00;
    logic          busy, done;
    logic [W-1:0]  result;

    as_seq dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .din    (din),
        .shamt  (shamt),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] value;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_t = -10;
    int   busy_until = -10;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, int sh, logic [1:0] o);
        case (o)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return $unsigned($signed(a) >>> sh);
            default: return (sh == 0) ? a : ((a >> sh) | (a << (W - sh)));
        endcase
    endfunction

    // Monitor: busy window, done timing and result value
    always @(negedge clock) begin
        if (resetn) begin
            logic exp_busy;
            exp_busy = (cyc >= last_t) && (cyc < busy_until);
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            if (done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_done cyc=%0d got result=%h want no done", cyc, result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (result !== e.value || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL done_result cyc=%0d got=%h want=%h at cyc %0d", cyc, result, e.value, e.cyc);
                    end else begin
                        $display("done cyc=%0d result=%h ok", cyc, result);
                    end
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_done cyc=%0d got done=0 want=%h", cyc, e.value);
            end
        end
    end

    // Drive one start pulse for one cycle; model decides whether it is accepted
    task automatic do_op(input logic [W-1:0] d, input int sh, input logic [1:0] o);
        int e;
        e = cyc + 1;
        din = d; shamt = sh[4:0]; op = o; start = 1'b1;
        if (e > busy_until) begin
            exp_t x;
            x.value = ref_shift(d, sh, o);
            x.cyc = e + sh;
            exp_q.push_back(x);
            last_t = e;
            busy_until = e + sh;
            $display("start edge=%0d din=%h shamt=%0d op=%0d accepted exp=%h", e, d, sh, o, x.value);
        end else begin
            $display("start edge=%0d din=%h shamt=%0d op=%0d ignored", e, d, sh, o);
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_edge(input int e);
        while (cyc + 1 < e) begin @(posedge clock); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin @(posedge clock); #1; n++; end
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_bad++;
            $display("FAIL %s got busy=%b done=%b result=%h want 0/0/0", tag, busy, done, result);
        end else begin
            $display("%s busy=0 done=0 result=0 ok", tag);
        end
    endtask

    initial begin
        #2 check_zero("reset_state");
        idle(2);
        resetn = 1'b1;
        idle(2);

        // Reset mid-shift: the operation is abandoned with no done
        do_op(32'h8000_0000, 10, 2'b10);
        idle(3);
        resetn = 1'b0;
        #1 check_zero("reset_mid_shift");
        exp_q.delete();
        last_t = -10; busy_until = -10;
        idle(2);
        resetn = 1'b1;
        idle(20);

        do_op(32'hF000_0000, 4, 2'b10); drain();
        do_op(32'h8000_0001, 31, 2'b01); drain();
        do_op(32'h8000_0001, 1, 2'b00); drain();
        do_op(32'h0000_0001, 1, 2'b11); drain();
        do_op(32'h1234_5678, 0, 2'b10); drain();

        // start during SHIFT is ignored
        do_op(32'h0F0F_0000, 6, 2'b01);
        idle(2);
        do_op(32'hDEAD_BEEF, 3, 2'b00);
        drain();

        // start in the DONE cycle is accepted back-to-back
        do_op(32'hA5A5_0001, 5, 2'b11);
        wait_edge(busy_until + 1);
        do_op(32'h8765_4321, 7, 2'b10);
        wait_edge(busy_until + 1);
        do_op(32'h0000_00FF, 0, 2'b00);
        wait_edge(busy_until + 1);
        do_op(32'hCAFE_F00D, 2, 2'b01);
        drain();

        for (int i = 0; i < 150; i++) begin
            do_op($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 12)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
